// File: rtl/join_pkg.sv
// Shared types and helpers for the N-way handshake join with skid output stage.
package join_pkg;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } occ_t;

  function automatic int payload_w(input int num_in, input int data_width);
    return num_in * data_width;
  endfunction

endpackage

// File: rtl/join_n_ready_gen.sv
// Combinational per-channel ready and all-valid generation for the N-way join.
module join_n_ready_gen #(
  parameter int NUM_IN = 2
) (
  input  logic              space,
  input  logic [NUM_IN-1:0] valid,
  output logic [NUM_IN-1:0] ready,
  output logic              all_valid
);

  assign all_valid = &valid;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_IN; gi++) begin : g_ch
      logic [NUM_IN-1:0] others;

      // A valid channel may only transfer once every other channel is valid too.
      always_comb begin
        others     = valid;
        others[gi] = 1'b1;
      end

      assign ready[gi] = space & (~valid[gi] | (&others));
    end
  endgenerate

endmodule

// File: rtl/join_n_skid.sv
// N-way handshake join feeding a registered 2-entry skid output stage.
// Optional performance counters are enabled with JOIN_N_SKID_PERF_EN.
module join_n_skid
  import join_pkg::*;
#(
  parameter int NUM_IN     = 2,
  parameter int DATA_WIDTH = 8
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [NUM_IN*DATA_WIDTH-1:0] data_in,
  input  logic [NUM_IN-1:0]            data_in_valid,
  output logic [NUM_IN-1:0]            data_in_ready,
  output logic [NUM_IN*DATA_WIDTH-1:0] data_out,
  output logic                         data_out_valid,
  input  logic                         data_out_ready
`ifdef JOIN_N_SKID_PERF_EN
  ,
  output logic [31:0]                  perf_beats,
  output logic [31:0]                  perf_wait
`endif
);

  localparam int PAYLOAD_W = payload_w(NUM_IN, DATA_WIDTH);

  occ_t                 state_reg, state_next;
  logic [PAYLOAD_W-1:0] main_data_reg, main_data_next;
  logic [PAYLOAD_W-1:0] skid_data_reg, skid_data_next;
  logic                 space, all_valid, accept, pop, main_valid;

  // space comes straight from the state register, so ready never sees data_out_ready.
  assign space      = (state_reg != FULL);
  assign main_valid = (state_reg != EMPTY);
  assign accept     = space & all_valid;
  assign pop        = main_valid & data_out_ready;

  join_n_ready_gen #(
    .NUM_IN(NUM_IN)
  ) u_ready_gen (
    .space    (space),
    .valid    (data_in_valid),
    .ready    (data_in_ready),
    .all_valid(all_valid)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg     <= EMPTY;
      main_data_reg <= '0;
      skid_data_reg <= '0;
    end else begin
      state_reg     <= state_next;
      main_data_reg <= main_data_next;
      skid_data_reg <= skid_data_next;
    end
  end

  always_comb begin
    state_next     = state_reg;
    main_data_next = main_data_reg;
    skid_data_next = skid_data_reg;
    case (state_reg)
      EMPTY: begin
        if (accept) begin
          state_next     = ONE;
          main_data_next = data_in;
        end
      end
      ONE: begin
        if (pop && accept) begin
          main_data_next = data_in;
        end else if (pop) begin
          state_next = EMPTY;
        end else if (accept) begin
          state_next     = FULL;
          skid_data_next = data_in;
        end
      end
      FULL: begin
        if (pop) begin
          state_next     = ONE;
          main_data_next = skid_data_reg;
        end
      end
      default: state_next = EMPTY;
    endcase
  end

  assign data_out       = main_data_reg;
  assign data_out_valid = main_valid;

`ifdef JOIN_N_SKID_PERF_EN
  logic [31:0] perf_beats_reg, perf_wait_reg;
  logic        partial;

  assign partial = (|data_in_valid) & ~all_valid;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      perf_beats_reg <= '0;
      perf_wait_reg  <= '0;
    end else begin
      if (accept)  perf_beats_reg <= perf_beats_reg + 32'd1;
      if (partial) perf_wait_reg  <= perf_wait_reg + 32'd1;
    end
  end

  assign perf_beats = perf_beats_reg;
  assign perf_wait  = perf_wait_reg;
`endif

endmodule

// File: tb/tb_join_n_skid.sv
// Scoreboard bench for join_n_skid: a driver pushes expected joined beats, a monitor pops and compares.
module tb_join_n_skid;

  localparam int N  = 3;
  localparam int W  = 8;
  localparam int PW = N * W;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic [PW-1:0] data_in = '0;
  logic [N-1:0]  data_in_valid = '0;
  logic [N-1:0]  data_in_ready;
  logic [PW-1:0] data_out;
  logic          data_out_valid;
  logic          data_out_ready = 1'b0;
`ifdef JOIN_N_SKID_PERF_EN
  logic [31:0]   perf_beats, perf_wait;
`endif

  int checks = 0;
  int fails  = 0;
  logic [PW-1:0] exp_q[$];
  int occ    = 0;
  int n_acc  = 0;
  int p_beats = 0;
  int p_wait  = 0;

  join_n_skid #(
    .NUM_IN    (N),
    .DATA_WIDTH(W)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .data_in       (data_in),
    .data_in_valid (data_in_valid),
    .data_in_ready (data_in_ready),
    .data_out      (data_out),
    .data_out_valid(data_out_valid),
    .data_out_ready(data_out_ready)
`ifdef JOIN_N_SKID_PERF_EN
    ,
    .perf_beats    (perf_beats),
    .perf_wait     (perf_wait)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [N-1:0] exp_rdy(input int o, input logic [N-1:0] v);
    logic [N-1:0] others;
    logic [N-1:0] r;
    r = '0;
    for (int i = 0; i < N; i++) begin
      others    = v;
      others[i] = 1'b1;
      r[i]      = (o < 2) && (!v[i] || (others == {N{1'b1}}));
    end
    return r;
  endfunction

  // One clock cycle of stimulus; the occupancy model decides what gets accepted/popped.
  task automatic cycle(input logic [N-1:0] v, input logic [PW-1:0] d, input logic r);
    logic acc, pp;
    @(posedge clk);
    #1;
    data_in_valid  = v;
    data_in        = d;
    data_out_ready = r;
    @(negedge clk);
    check("in_ready", 32'(data_in_ready), 32'(exp_rdy(occ, v)));
    check("out_valid", 32'(data_out_valid), 32'(occ > 0));
    acc = (occ < 2) && (v == {N{1'b1}});
    pp  = (occ > 0) && r;
    if (acc) begin
      exp_q.push_back(d);
      n_acc++;
      p_beats++;
    end
    if (v != '0 && v != {N{1'b1}}) p_wait++;
    occ = occ + int'(acc) - int'(pp);
  endtask

  // Monitor: compare every output handshake against the scoreboard and check stall stability.
  initial begin
    logic          stall_prev;
    logic [PW-1:0] held;
    stall_prev = 1'b0;
    held       = '0;
    forever begin
      @(negedge clk);
      if (!rst) begin
        stall_prev = 1'b0;
      end else begin
        if (stall_prev) check("stall_stable", 32'(data_out), 32'(held));
        if (data_out_valid && data_out_ready) begin
          if (exp_q.size() == 0) begin
            checks++;
            fails++;
            $display("FAIL unexpected_beat: got %h expected none at %0t", data_out, $time);
          end else begin
            check("out_data", 32'(data_out), 32'(exp_q.pop_front()));
          end
        end
        stall_prev = data_out_valid && !data_out_ready;
        held       = data_out;
      end
    end
  end

  initial begin
    int acc_start;
    int cyc;
    logic [N-1:0]  v;
    logic [PW-1:0] d;
    logic          r;

    // Reset state
    #3;
    check("rst_out_valid", 32'(data_out_valid), 32'd0);
    check("rst_out_data", 32'(data_out), 32'd0);
    check("rst_in_ready", 32'(data_in_ready), 32'h7);
    @(posedge clk);
    #1 rst = 1'b1;

    // Basic join: 0x11/0x22/0x33 -> 0x332211 one cycle later
    cycle(3'b111, 24'h332211, 1'b1);
    cycle(3'b000, 24'h000000, 1'b1);

    // Channel 0 alone for five cycles, then all three valid: one beat only
    repeat (5) cycle(3'b001, 24'h0000AA, 1'b1);
    cycle(3'b111, 24'hCCBBAA, 1'b1);
    cycle(3'b000, 24'h000000, 1'b1);
    cycle(3'b000, 24'h000000, 1'b1);

    // Fill to FULL with A then B under backpressure, then drain
    cycle(3'b111, 24'hA1A2A3, 1'b0);
    cycle(3'b111, 24'hB1B2B3, 1'b0);
    cycle(3'b111, 24'hC1C2C3, 1'b0);
    cycle(3'b000, 24'h000000, 1'b1);
    cycle(3'b000, 24'h000000, 1'b1);
    cycle(3'b000, 24'h000000, 1'b1);

    // Asynchronous reset while FULL
    cycle(3'b111, 24'hD1D2D3, 1'b0);
    cycle(3'b111, 24'hE1E2E3, 1'b0);
    cycle(3'b000, 24'h000000, 1'b0);
    #2 rst = 1'b0;
    #1;
    check("async_rst_valid", 32'(data_out_valid), 32'd0);
    check("async_rst_data", 32'(data_out), 32'd0);
    check("async_rst_ready", 32'(data_in_ready), 32'h7);
    exp_q.delete();
    occ     = 0;
    p_beats = 0;
    p_wait  = 0;
    @(posedge clk);
    @(posedge clk);
    #1 rst = 1'b1;
    cycle(3'b111, 24'h5A6B7C, 1'b1);
    cycle(3'b000, 24'h000000, 1'b1);

    // Random streaming of 100 joined beats
    acc_start = n_acc;
    cyc       = 0;
    while ((n_acc - acc_start) < 100 && cyc < 5000) begin
      for (int i = 0; i < N; i++) v[i] = ($urandom_range(0, 3) != 0);
      d = PW'($urandom);
      r = ($urandom_range(0, 2) != 0);
      cycle(v, d, r);
      cyc++;
    end
    check("rand_beats_done", 32'((n_acc - acc_start) >= 100), 32'd1);

    repeat (4) cycle(3'b000, 24'h000000, 1'b1);
    check("drain_empty", 32'(exp_q.size()), 32'd0);
`ifdef JOIN_N_SKID_PERF_EN
    check("perf_beats", perf_beats, 32'(p_beats));
    check("perf_wait", perf_wait, 32'(p_wait));
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule

// File: doc/join_n_skid.md
Name: join_n_skid

Overview:
- Parametrised N-way handshake join with a data payload and a registered 2-entry skid output stage.
- Waits until all NUM_IN input streams present valid data, consumes one beat from each in the same cycle, and emits the concatenated payload as one output beat.
- Breaks the combinational data_out_ready -> data_in_ready path.
- Used wherever parallel operand streams (e.g. mantissa/exponent, weight/activation lanes) must be synchronised before a compute stage.

Parameters:
- NUM_IN, 2, number of input channels (>=2).
- DATA_WIDTH, 8, payload bits per input channel (>=1).

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  asynchronous, active-low reset (0 = reset asserted).
- data_in  input  NUM_IN*DATA_WIDTH  packed payloads; channel i occupies bits [i*DATA_WIDTH +: DATA_WIDTH].
- data_in_valid  input  NUM_IN  per-channel valid.
- data_in_ready  output  NUM_IN  per-channel ready.
- data_out  output  NUM_IN*DATA_WIDTH  joined payload, same packing as data_in.
- data_out_valid  output  1  output beat valid.
- data_out_ready  input  1  downstream ready.

Behaviour:
- State: main register (main_valid, main_data) and skid register (skid_valid, skid_data). Occupancy states:
  - EMPTY: main_valid=0, skid_valid=0.
  - ONE: main_valid=1, skid_valid=0.
  - FULL: both valid.
- space = !skid_valid. This is registered, so it has no combinational dependence on data_out_ready.
- all_valid = &data_in_valid.
- data_in_ready[i] = space & (!data_in_valid[i] | &data_in_valid[j != i]).
  - A lone valid channel is held (ready=0) until all others are valid.
  - Invalid channels see ready=space.
- accept = space & all_valid. On accept, every channel transfers its beat in the same cycle; no partial consumption ever occurs.
- data_out = main_data; data_out_valid = main_valid.
- pop = main_valid & data_out_ready.
- Transitions:
  - EMPTY: accept -> ONE (main <= data_in).
  - ONE, pop & accept -> ONE (main <= data_in).
  - ONE, pop & !accept -> EMPTY.
  - ONE, !pop & accept -> FULL (skid <= data_in).
  - ONE, !pop & !accept -> ONE.
  - FULL: accept impossible (space=0). pop -> ONE (main <= skid_data, skid_valid <= 0); otherwise hold.
- Latency: a joined beat accepted in cycle t is visible on data_out in cycle t+1 when the stage was EMPTY, or when it was ONE with a pop in cycle t.
- Throughput: 1 beat/cycle sustained while data_out_ready=1.
- Ordering: strictly FIFO; payload bits pass unmodified.
- data_out holds stable while data_out_valid=1 and data_out_ready=0 (AXI-stream rule).
- Reset (asynchronous assert, any time, including mid-transfer):
  - main_valid=0, skid_valid=0, data_out_valid=0, data registers cleared to 0.
  - data_in_ready then equals the space term (1) gated by the valid pattern.
  - In-flight beats are discarded.
- Release of reset is synchronised by the integrator; the block needs no extra idle cycles after release.
- Simultaneous pop and accept in ONE state must not lose or duplicate a beat.

Optional Feature:
- Macro JOIN_N_SKID_PERF_EN.
- When defined, adds outputs:
  - perf_beats (32b): count of accept cycles.
  - perf_wait (32b): count of cycles where some but not all data_in_valid bits are high.
  - Both counters clear on reset, wrap modulo 2^32, and do not saturate.
- When undefined: no extra ports or registers; behaviour is otherwise identical.

Decomposition:
- Shared package join_pkg:
  - occupancy state enum (EMPTY, ONE, FULL), 2-bit encoding.
  - localparam helper for PAYLOAD_W = NUM_IN*DATA_WIDTH as a function.
- Sub-module join_n_ready_gen: purely combinational per-channel ready/all_valid generation, parametrised by NUM_IN.
- join_n_skid instantiates join_n_ready_gen plus the skid state machine.

Test Plan:
- NUM_IN=3, DATA_WIDTH=8; channels valid with 0x11/0x22/0x33, data_out_ready=1 -> next cycle data_out=0x332211, data_out_valid=1; all data_in_ready=1 during accept.
- Channel 0 valid alone for 5 cycles, others valid at cycle 5 -> data_in_ready[0]=0 for cycles 0-4; single accept at cycle 5; exactly one output beat.
- data_out_ready=0, two joined beats A then B -> state FULL, all data_in_ready=0. Raise ready -> A then B on consecutive cycles, no loss or duplication.
- Streaming 100 random beats with random valids and random data_out_ready -> output sequence equals the input join sequence exactly, in order, and data_out stable during stalls.
- Assert rst=0 asynchronously while in FULL -> data_out_valid=0 immediately, before the next edge; after release, first new beat is emitted normally.
- With JOIN_N_SKID_PERF_EN: 10 accepts plus 4 partial-valid cycles -> perf_beats=10, perf_wait=4; preload to 0xFFFFFFFF, then one accept -> wraps to 0.
